lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- Responder on the core's memory-mapped LCD write path. The LSU issues byte writes with a valid/ready handshake; this block turns each write into HD44780-compatible bus timing on the character-LCD pins.
- Handles power-on wait, optional auto-init, the enable-pulse setup/width/hold, and per-command execution delay.
- Software only needs to check `o_busy`/`o_req_rdy`; it never bit-bangs EN.

Parameters:
- `POWERON_CYC`, 750000: cycles held after reset before any LCD access (15 ms @ 50 MHz).
- `SETUP_CYC`, 2: RS/DATA-valid cycles before EN rises (>= 40 ns).
- `EN_CYC`, 12: EN high width in cycles (>= 240 ns).
- `HOLD_CYC`, 2: RS/DATA hold cycles after EN falls.
- `EXEC_CYC`, 2000: post-write execution delay for normal commands and data (40 us).
- `CLEAR_CYC`, 82000: post-write execution delay for clear (0x01) and home (0x02/0x03) with RS=0 (1.64 ms).

Ports:
- `i_clk`  in  1  system clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_req_vld`  in  1  LSU write request valid
- `o_req_rdy`  out  1  block accepts a request this cycle
- `i_req_rs`  in  1  0 = command, 1 = character data
- `i_req_data`  in  8  command/data byte
- `o_busy`  out  1  equals ~`o_req_rdy`; readable by software through the LSU
- `o_init_done`  out  1  power-on wait (and init sequence, if enabled) complete
- `o_lcd_on`  out  1  LCD power/backlight enable
- `o_lcd_rs`  out  1  LCD register select
- `o_lcd_rw`  out  1  LCD read/write; tied 0 (write only)
- `o_lcd_en`  out  1  LCD enable strobe
- `o_lcd_data`  out  8  LCD data bus

Behaviour:
- All state and outputs are registered. Reset is sampled only on a rising `i_clk` with `i_reset`=1.
- Reset values: `o_req_rdy`=0, `o_busy`=1, `o_init_done`=0, `o_lcd_on`=1, `o_lcd_rs`=0, `o_lcd_rw`=0, `o_lcd_en`=0, `o_lcd_data`=8'h00. Counter=0, state=PWRON, init index=0.
- FSM states: PWRON, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, EXEC.
- PWRON: count `POWERON_CYC` cycles, then go to INIT_LOAD (macro on) or IDLE with `o_init_done`=1 (macro off).
- IDLE: `o_req_rdy`=1.
  - A handshake is `i_req_vld` & `o_req_rdy` on the same edge.
  - On a handshake, latch `i_req_rs`/`i_req_data` onto `o_lcd_rs`/`o_lcd_data`, drop `o_req_rdy` the next cycle, and go to SETUP.
- SETUP: hold for `SETUP_CYC` cycles, then PULSE.
- PULSE: `o_lcd_en`=1 for exactly `EN_CYC` cycles, then HOLD.
- HOLD: `o_lcd_en`=0; RS/DATA unchanged for `HOLD_CYC` cycles, then EXEC.
- EXEC: wait `CLEAR_CYC` if RS=0 and data[7:1]==7'b0000000 or data==8'h02/8'h03; otherwise wait `EXEC_CYC`. Then return to IDLE (or INIT_LOAD while init is incomplete).
- Counter is 20 bits wide, reloads to 0 on every state change, and compares against (param-1). Each state lasts exactly its parameter count.
- `o_lcd_rs`/`o_lcd_data` change only on a handshake or INIT_LOAD. They stay stable from SETUP through HOLD inclusive.
- Requests arriving while `o_req_rdy`=0 are ignored, not queued. The LSU must keep `i_req_vld` asserted until the handshake.
- Back-to-back: the earliest next accept is on the cycle after EXEC ends. Total cycles per write = 1 + `SETUP_CYC` + `EN_CYC` + `HOLD_CYC` + exec delay.
- `i_reset` mid-transaction: next cycle `o_lcd_en`=0, all outputs return to reset values, and the FSM restarts at PWRON. No partial EN pulse may extend past the reset edge.
- `o_lcd_rw` is never driven 1.

Optional Feature:
- Macro: `LCD_AUTO_INIT_EN`.
- Defined: after PWRON the block issues, with no handshake, the RS=0 sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Each entry uses full SETUP/PULSE/HOLD/EXEC timing; 0x01 uses `CLEAR_CYC`. `o_init_done` rises on entering IDLE after the sixth command. `o_req_rdy` stays 0 throughout.
- Undefined: PWRON goes straight to IDLE, with `o_init_done`=1 on the same cycle; software performs init itself. No ROM or index logic is present.

Test Plan:
All tests use `POWERON_CYC`=10, `SETUP_CYC`=2, `EN_CYC`=4, `HOLD_CYC`=2, `EXEC_CYC`=8, `CLEAR_CYC`=20.
1. Reset, macro off -> `o_req_rdy`=0 for 10 cycles after reset release, then 1; `o_init_done`=1 on that cycle; `o_lcd_en` stays 0.
2. Write rs=1, data=8'h41 -> `o_lcd_data`=8'h41 and `o_lcd_rs`=1 from the cycle after the handshake. EN high for exactly 4 cycles, starting 2 cycles after latch. `o_req_rdy` returns 1 exactly 17 cycles after the handshake edge (1+2+4+2+8).
3. Write rs=0, data=8'h01 -> same pulse; `o_req_rdy` returns after 29 cycles (clear delay). Repeat with rs=1, data=8'h01 -> 17 cycles.
4. Hold `i_req_vld`=1 with data 8'h41 then 8'h42 -> exactly two EN pulses; data stable across each pulse; second accept occurs only when `o_req_rdy`=1.
5. Assert `i_reset` during PULSE -> `o_lcd_en`=0 the next cycle, `o_lcd_data`=8'h00, `o_busy`=1, PWRON restarts for 10 cycles.
6. Macro on -> after PWRON, six EN pulses with data 38, 38, 38, 0C, 01, 06 and RS=0; the 01 pulse is followed by a 20-cycle exec. `o_init_done` and `o_req_rdy` rise together after the sixth pulse; requests asserted during init are not accepted.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD write controller: turns LSU byte writes into RS/DATA/EN bus timing.
// Optional power-on init sequence is built in when LCD_AUTO_INIT_EN is defined.
module lcd_ctrl #(
    parameter int unsigned POWERON_CYC = 750000,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned EN_CYC      = 12,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned EXEC_CYC    = 2000,
    parameter int unsigned CLEAR_CYC   = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_vld,
    output logic       o_req_rdy,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_data
);

    typedef enum logic [2:0] {PWRON, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

    localparam logic [19:0] PWRON_LAST = 20'(POWERON_CYC - 1);
    localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYC - 1);
    localparam logic [19:0] EN_LAST    = 20'(EN_CYC - 1);
    localparam logic [19:0] HOLD_LAST  = 20'(HOLD_CYC - 1);
    localparam logic [19:0] EXEC_LAST  = 20'(EXEC_CYC - 1);
    localparam logic [19:0] CLEAR_LAST = 20'(CLEAR_CYC - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        rdy_q, rdy_d;
    logic        busy_q;
    logic        init_done_q, init_done_d;
    logic        en_q, en_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        long_exec;
    logic [19:0] exec_last;

    // Clear (0x01/0x00) and home (0x02/0x03) commands need the long execution delay.
    assign long_exec = ~rs_q & (data_q[7:1] == 7'b0000000 || data_q[7:1] == 7'b0000001);
    assign exec_last = long_exec ? CLEAR_LAST : EXEC_LAST;

`ifdef LCD_AUTO_INIT_EN
    logic [2:0] idx_q, idx_d;
    logic [7:0] init_byte;

    always_comb begin
        case (idx_q)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;
            3'd3:             init_byte = 8'h0C;
            3'd4:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 20'd1;
        rdy_d       = rdy_q;
        init_done_d = init_done_q;
        en_d        = en_q;
        rs_d        = rs_q;
        data_d      = data_q;
`ifdef LCD_AUTO_INIT_EN
        idx_d       = idx_q;
`endif
        case (state_q)
            PWRON: begin
                if (cnt_q == PWRON_LAST) begin
                    cnt_d = 20'd0;
`ifdef LCD_AUTO_INIT_EN
                    state_d = INIT_LOAD;
`else
                    state_d     = IDLE;
                    rdy_d       = 1'b1;
                    init_done_d = 1'b1;
`endif
                end
            end
            INIT_LOAD: begin
                cnt_d   = 20'd0;
                state_d = SETUP;
`ifdef LCD_AUTO_INIT_EN
                rs_d    = 1'b0;
                data_d  = init_byte;
                idx_d   = idx_q + 3'd1;
`endif
            end
            IDLE: begin
                cnt_d = 20'd0;
                if (i_req_vld && rdy_q) begin
                    rs_d    = i_req_rs;
                    data_d  = i_req_data;
                    rdy_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 20'd0;
                    en_d    = 1'b1;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d   = 20'd0;
                    en_d    = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 20'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == exec_last) begin
                    cnt_d       = 20'd0;
                    state_d     = IDLE;
                    rdy_d       = 1'b1;
                    init_done_d = 1'b1;
`ifdef LCD_AUTO_INIT_EN
                    if (idx_q != 3'd6) begin
                        state_d     = INIT_LOAD;
                        rdy_d       = 1'b0;
                        init_done_d = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_d = PWRON;
                cnt_d   = 20'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= PWRON;
            cnt_q       <= 20'd0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
`ifdef LCD_AUTO_INIT_EN
            idx_q       <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
            busy_q      <= ~rdy_d;
            init_done_q <= init_done_d;
            en_q        <= en_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
`ifdef LCD_AUTO_INIT_EN
            idx_q       <= idx_d;
`endif
        end
    end

    assign o_req_rdy   = rdy_q;
    assign o_busy      = busy_q;
    assign o_init_done = init_done_q;
    assign o_lcd_on    = 1'b1;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = en_q;
    assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters; the auto-init
// scenario runs instead of the write scenarios when LCD_AUTO_INIT_EN is defined.
module tb_lcd_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_req_vld = 1'b0;
    logic       i_req_rs = 1'b0;
    logic [7:0] i_req_data = 8'h00;
    logic       o_req_rdy, o_busy, o_init_done, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
    logic [7:0] o_lcd_data;

    int checks = 0;
    int errors = 0;

    lcd_ctrl #(
        .POWERON_CYC(10), .SETUP_CYC(2), .EN_CYC(4),
        .HOLD_CYC(2), .EXEC_CYC(8), .CLEAR_CYC(20)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
        .i_req_rs(i_req_rs), .i_req_data(i_req_data),
        .o_busy(o_busy), .o_init_done(o_init_done), .o_lcd_on(o_lcd_on),
        .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en),
        .o_lcd_data(o_lcd_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},  32'(o_req_rdy),   32'd0);
        check({tag, "_busy"}, 32'(o_busy),      32'd1);
        check({tag, "_done"}, 32'(o_init_done), 32'd0);
        check({tag, "_on"},   32'(o_lcd_on),    32'd1);
        check({tag, "_rs"},   32'(o_lcd_rs),    32'd0);
        check({tag, "_rw"},   32'(o_lcd_rw),    32'd0);
        check({tag, "_en"},   32'(o_lcd_en),    32'd0);
        check({tag, "_data"}, 32'(o_lcd_data),  32'd0);
    endtask

`ifndef LCD_AUTO_INIT_EN
    // Called right after the reset edge with reset already released.
    task automatic wait_pwron(input string tag);
        int early = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (o_req_rdy !== 1'b0 || o_lcd_en !== 1'b0) early++;
        end
        check({tag, "_pwron_quiet"}, 32'(early), 32'd0);
        step();
        check({tag, "_rdy_up"},  32'(o_req_rdy),   32'd1);
        check({tag, "_done_up"}, 32'(o_init_done), 32'd1);
        check({tag, "_busy_dn"}, 32'(o_busy),      32'd0);
        $display("pwron %s: rdy=%0d init_done=%0d", tag, o_req_rdy, o_init_done);
    endtask

    // Issue one write from IDLE and follow it until o_req_rdy returns.
    task automatic do_write(input string tag, input logic rs, input logic [7:0] d, input int exp_cycles);
        int n = 0, en_cnt = 0, en_first = -1, unstable = 0;
        i_req_vld = 1'b1; i_req_rs = rs; i_req_data = d;
        step();
        i_req_vld = 1'b0; i_req_rs = ~rs; i_req_data = ~d;
        check({tag, "_data"}, 32'(o_lcd_data), 32'(d));
        check({tag, "_rs"},   32'(o_lcd_rs),   32'(rs));
        check({tag, "_busy"}, 32'(o_busy),     32'd1);
        while (o_req_rdy !== 1'b1 && n < 200) begin
            step();
            n++;
            if (o_lcd_en === 1'b1) begin
                en_cnt++;
                if (en_first < 0) en_first = n;
            end
            if (o_lcd_data !== d || o_lcd_rs !== rs) unstable++;
        end
        check({tag, "_cycles"},   32'(n + 1),  32'(exp_cycles));
        check({tag, "_en_start"}, 32'(en_first), 32'd2);
        check({tag, "_en_width"}, 32'(en_cnt),   32'd4);
        check({tag, "_stable"},   32'(unstable), 32'd0);
        $display("write %s: rs=%0d data=%02h cycles=%0d en_start=%0d en_width=%0d",
                 tag, rs, d, n + 1, en_first, en_cnt);
    endtask
`endif

    initial begin
`ifndef LCD_AUTO_INIT_EN
        int acc, pulses, unstable, gap;
        int acc_cyc[3];
        logic [7:0] pdata[3];
        logic prev_rdy, prev_en;
        logic [7:0] prev_data;

        // Reset state and power-on wait
        step();
        step();
        check_reset_vals("reset");
        i_reset = 1'b0;
        wait_pwron("t1");

        // Single writes, normal and clear/home delays
        do_write("t2_41",   1'b1, 8'h41, 17);
        do_write("t3_clr",  1'b0, 8'h01, 29);
        do_write("t3_d01",  1'b1, 8'h01, 17);
        do_write("t3_home", 1'b0, 8'h03, 29);
        do_write("t3_cmd",  1'b0, 8'h38, 17);

        // Valid held across two writes
        acc = 0; pulses = 0; unstable = 0;
        i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h41;
        for (int cyc = 0; cyc < 100; cyc++) begin
            prev_rdy = o_req_rdy; prev_en = o_lcd_en; prev_data = o_lcd_data;
            step();
            if (prev_rdy && i_req_vld) begin
                acc++;
                acc_cyc[acc] = cyc;
                if (acc == 1) i_req_data = 8'h42;
                else i_req_vld = 1'b0;
            end
            if (o_lcd_en && !prev_en && pulses < 2) begin
                pulses++;
                pdata[pulses] = o_lcd_data;
            end
            if (o_lcd_en && prev_en && o_lcd_data !== prev_data) unstable++;
            if (acc == 2 && o_req_rdy) break;
        end
        gap = acc_cyc[2] - acc_cyc[1];
        check("t4_pulses",  32'(pulses),   32'd2);
        check("t4_p1_data", 32'(pdata[1]), 32'h41);
        check("t4_p2_data", 32'(pdata[2]), 32'h42);
        check("t4_stable",  32'(unstable), 32'd0);
        check("t4_gap",     32'(gap),      32'd17);
        $display("b2b: pulses=%0d p1=%02h p2=%02h accept_gap=%0d", pulses, pdata[1], pdata[2], gap);

        // Reset in the middle of the enable pulse
        i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h55;
        step();
        i_req_vld = 1'b0;
        step(); step(); step();
        check("t5_in_pulse", 32'(o_lcd_en), 32'd1);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check_reset_vals("t5");
        $display("reset mid-pulse: en=%0d data=%02h busy=%0d", o_lcd_en, o_lcd_data, o_busy);
        wait_pwron("t5");
`else
        logic [7:0] exp_init[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        logic [7:0] pdata[6];
        logic       prs[6];
        int         gaps[6];
        int pulses = 0, lowrun = 0, first_en = -1, n = 0, sync_bad = 0, rdy_pulses = -1;
        logic prev_en = 1'b0;

        step();
        check_reset_vals("reset");
        i_reset = 1'b0;
        i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h55;
        while (n < 500) begin
            step();
            n++;
            if (o_init_done !== o_req_rdy) sync_bad++;
            if (o_lcd_en && !prev_en) begin
                if (first_en < 0) first_en = n;
                if (pulses < 6) begin
                    pdata[pulses] = o_lcd_data;
                    prs[pulses] = o_lcd_rs;
                    gaps[pulses] = lowrun;
                end
                pulses++;
            end
            lowrun = o_lcd_en ? 0 : lowrun + 1;
            prev_en = o_lcd_en;
            if (o_req_rdy === 1'b1) begin
                rdy_pulses = pulses;
                break;
            end
        end
        i_req_vld = 1'b0;
        check("t6_first_en",  32'(first_en),   32'd13);
        check("t6_pulses",    32'(rdy_pulses), 32'd6);
        check("t6_sync",      32'(sync_bad),   32'd0);
        check("t6_done",      32'(o_init_done), 32'd1);
        check("t6_tail",      32'(lowrun),     32'd11);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t6_data%0d", k), 32'(pdata[k]), 32'(exp_init[k]));
            check($sformatf("t6_rs%0d", k),   32'(prs[k]),   32'd0);
            if (k > 0) check($sformatf("t6_gap%0d", k), 32'(gaps[k]), (k == 5) ? 32'd25 : 32'd13);
            $display("init pulse %0d: rs=%0d data=%02h gap=%0d", k, prs[k], pdata[k], gaps[k]);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
